// File: rtl/alu_arb_pkg.sv
// Shared types and ALU control encodings for the alu_arbiter block.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Index of the requester that owns the ALU (0 or 1).
    typedef logic grant_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_arb_rr.sv
// Two-port round-robin grant generator: a lone valid port wins, a tie goes to
// the pointer, and the pointer flips to the other port after every grant.
module alu_arb_rr
    import alu_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output grant_t     grant
);

    grant_t ptr;

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = ptr;
        if (valid == 2'b01) begin
            grant = 1'b0;
        end else if (valid == 2'b10) begin
            grant = 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~grant;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_op1,
    input  logic [WIDTH-1:0]  req0_op2,
    input  logic [CTRL_W-1:0] req0_ctrl,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_op1,
    input  logic [WIDTH-1:0]  req1_op2,
    input  logic [CTRL_W-1:0] req1_ctrl,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_eq,

    output logic [WIDTH-1:0]  alu_op1,
    output logic [WIDTH-1:0]  alu_op2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_eq
);

    state_t            state;
    grant_t            gnt_idx;
    grant_t            arb_idx;
    logic [WIDTH-1:0]  op1_q;
    logic [WIDTH-1:0]  op2_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [WIDTH-1:0]  result_q;
    logic              eq_q;
    logic              accept;
    logic              rsp_take;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign arb_idx = grant_t'(!req0_valid && req1_valid);
`else
    alu_arb_rr u_rr (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (arb_idx)
    );
`endif

    // Ready is gated by rst so a requester never sees a handshake the
    // synchronous reset is about to discard.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == ST_IDLE && !rst) begin
            req0_ready = req0_valid && (arb_idx == 1'b0);
            req1_ready = req1_valid && (arb_idx == 1'b1);
        end
    end

    assign accept     = req0_ready || req1_ready;
    assign rsp0_valid = (state == ST_RESP) && (gnt_idx == 1'b0);
    assign rsp1_valid = (state == ST_RESP) && (gnt_idx == 1'b1);
    assign rsp_take   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_result = result_q;
    assign rsp_eq     = eq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt_idx  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            eq_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_idx <= arb_idx;
                        op1_q   <= arb_idx ? req1_op1  : req0_op1;
                        op2_q   <= arb_idx ? req1_op2  : req0_op2;
                        ctrl_q  <= arb_idx ? req1_ctrl : req0_ctrl;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= alu_result;
                    eq_q     <= alu_eq;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_take) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response scoreboard.
// Honours ALU_ARB_FIXED_PRIO_EN the same way as the design.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0]  req0_op1, req0_op2, req1_op1, req1_op2;
    logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
    logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_eq;
    logic [WIDTH-1:0]  alu_op1, alu_op2, alu_result;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_eq;

    typedef struct {
        bit               port;
        logic [WIDTH-1:0] result;
        logic             eq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   accept_cyc;
    bit   exp_ptr;

    alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op1   (req0_op1),
        .req0_op2   (req0_op2),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op1   (req1_op1),
        .req1_op2   (req1_op2),
        .req1_ctrl  (req1_ctrl),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_eq     (rsp_eq),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_eq     (alu_eq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU stand-in.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD: alu_result = alu_op1 + alu_op2;
            ALU_SUB: alu_result = alu_op1 - alu_op2;
            ALU_AND: alu_result = alu_op1 & alu_op2;
            ALU_OR:  alu_result = alu_op1 | alu_op2;
            ALU_SLT: alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
        alu_eq = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop one expectation per response handshake.
    always @(negedge clk) begin
        if (!rst && (rsp0_valid || rsp1_valid)) begin
            check("rsp_valid_onehot", 64'(rsp0_valid && rsp1_valid), 0);
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                check("rsp_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_port",   64'(rsp1_valid), 64'(e.port));
                    check("rsp_result", 64'(rsp_result), 64'(e.result));
                    check("rsp_eq",     64'(rsp_eq), 64'(e.eq));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic set_req(input bit port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [CTRL_W-1:0] c, input logic v);
        if (port) begin
            req1_op1 = a; req1_op2 = b; req1_ctrl = c; req1_valid = v;
        end else begin
            req0_op1 = a; req0_op2 = b; req0_ctrl = c; req0_valid = v;
        end
    endtask

    // Waits (bounded) for an accept; returns at posedge+1 of the EXEC cycle.
    task automatic wait_accept(input bit port, input bit push, input logic [WIDTH-1:0] res,
                               input logic eq, output int waited);
        bit got = 0;
        waited = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                got = 1;
            end else begin
                waited++;
                @(posedge clk); #1;
            end
        end
        check("accept_seen", 64'(got), 1);
        if (got) begin
            check("accept_port", 64'(req1_ready), 64'(port));
            check("ready_onehot", 64'(req0_ready && req1_ready), 0);
            if (push) begin
                exp_t e;
                e.port = port; e.result = res; e.eq = eq;
                sb.push_back(e);
            end
            accept_cyc = cyc;
            exp_ptr    = ~port;
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(input bit port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [CTRL_W-1:0] c, input bit push,
                         input logic [WIDTH-1:0] res, input logic eq);
        int w;
        set_req(port, a, b, c, 1'b1);
        wait_accept(port, push, res, eq, w);
        set_req(port, '0, '0, '0, 1'b0);
    endtask

    // Called in EXEC: checks the T+1 / T+2 timing and returns back in IDLE.
    task automatic expect_rsp(input bit port, input logic [WIDTH-1:0] op1);
        @(negedge clk);
        check("exec_no_rsp", 64'({rsp1_valid, rsp0_valid}), 0);
        check("exec_no_ready", 64'({req1_ready, req0_ready}), 0);
        check("exec_alu_op1", 64'(alu_op1), 64'(op1));
        @(posedge clk); #1;
        @(negedge clk);
        check("resp_valid", 64'({rsp1_valid, rsp0_valid}), port ? 64'd2 : 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        int prev;
        bit win;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_op1 = '0; req0_op2 = '0; req0_ctrl = '0;
        req1_op1 = '0; req1_op2 = '0; req1_ctrl = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        exp_ptr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_req_ready", 64'({req1_ready, req0_ready}), 0);
        check("reset_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 0);
        check("reset_alu_op1", 64'(alu_op1), 0);
        check("reset_alu_op2", 64'(alu_op2), 0);
        check("reset_alu_ctrl", 64'(alu_ctrl), 0);
        check("reset_result", 64'(rsp_result), 0);
        check("reset_eq", 64'(rsp_eq), 0);
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b0;

        // Single ops on each port, including the EQ and SLT cases.
        issue(0, 32'd5, 32'd3, ALU_ADD, 1, 32'd8, 1'b0);
        expect_rsp(0, 32'd5);
        issue(1, 32'h1234, 32'h1234, ALU_SUB, 1, 32'd0, 1'b1);
        expect_rsp(1, 32'h1234);
        issue(0, 32'd2, 32'd7, ALU_SLT, 1, 32'd1, 1'b0);
        expect_rsp(0, 32'd2);
        issue(1, 32'hF0F0, 32'h0FF0, ALU_AND, 1, 32'h00F0, 1'b0);
        expect_rsp(1, 32'hF0F0);
        issue(0, 32'hF000, 32'h000F, ALU_OR, 1, 32'hF00F, 1'b0);
        expect_rsp(0, 32'hF000);

        // Contention: both valid continuously, responses taken immediately.
        set_req(0, 32'd10, 32'd20, ALU_ADD, 1'b1);
        set_req(1, 32'd50, 32'd8, ALU_SUB, 1'b1);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = exp_ptr;
`endif
            wait_accept(win, 1, win ? 32'd42 : 32'd30, 1'b0, w);
            if (k > 0) check("accept_spacing", 64'(accept_cyc - prev), 3);
            prev = accept_cyc;
        end
        set_req(0, '0, '0, '0, 1'b0);
        set_req(1, '0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure on port 0 while port 1 waits.
        rsp0_ready = 1'b0;
        issue(0, 32'd100, 32'd1, ALU_SUB, 1, 32'd99, 1'b0);
        set_req(1, 32'd7, 32'd7, ALU_ADD, 1'b1);
        @(negedge clk);
        check("bp_exec_ready", 64'({req1_ready, req0_ready}), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_rsp0_valid", 64'(rsp0_valid), 1);
            check("bp_result_stable", 64'(rsp_result), 32'd99);
            check("bp_ready_low", 64'({req1_ready, req0_ready}), 0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'({req1_ready, req0_ready}), 0);
        @(posedge clk); #1;
        wait_accept(1, 1, 32'd14, 1'b0, w);
        check("bp_pending_accept_delay", 64'(w), 0);
        set_req(1, '0, '0, '0, 1'b0);
        expect_rsp(1, 32'd7);

        // Reset in EXEC discards the operation.
        issue(0, 32'd1, 32'd1, ALU_ADD, 0, '0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ptr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 0);
            check("rst_req_ready", 64'({req1_ready, req0_ready}), 0);
            @(posedge clk); #1;
        end
        check("rst_result", 64'(rsp_result), 0);
        check("rst_alu_op1", 64'(alu_op1), 0);

        // After reset the pointer is back on port 0.
        set_req(0, 32'd10, 32'd20, ALU_ADD, 1'b1);
        set_req(1, 32'd50, 32'd8, ALU_SUB, 1'b1);
        wait_accept(0, 1, 32'd30, 1'b0, w);
        set_req(0, '0, '0, '0, 1'b0);
        set_req(1, '0, '0, '0, 1'b0);
        expect_rsp(0, 32'd10);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters, e.g. the execute stage and a multi-cycle helper such as an address or branch-compare unit. Each request is accepted through a valid/ready handshake. The accepted operands and control are registered and driven into the ALU for one cycle. The result and EQ flag are captured and returned to the winning requester through its own valid/ready response channel. Arbitration is round-robin by default, with a compile-time fixed-priority option.

## Interface
Parameters:
- WIDTH, 32, operand and result width
- CTRL_W, 3, ALU control width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- req0_valid / req1_valid  in  1  requester N has an operation
- req0_ready / req1_ready  out  1  requester N's operation is accepted this cycle
- req0_op1, req0_op2 / req1_op1, req1_op2  in  WIDTH  operands
- req0_ctrl / req1_ctrl  in  CTRL_W  ALU control code, passed through unmodified
- rsp0_valid / rsp1_valid  out  1  response available for requester N
- rsp0_ready / rsp1_ready  in  1  requester N takes its response
- rsp_result  out  WIDTH  captured ALU result, shared by both response channels
- rsp_eq  out  1  captured ALU EQ flag (result == 0)
- alu_op1, alu_op2  out  WIDTH  to ALU ALUop1 / ALUop2
- alu_ctrl  out  CTRL_W  to ALU ALUctrl
- alu_result  in  WIDTH  from ALU Result
- alu_eq  in  1  from ALU EQ

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready = 1 only for the granted port, and only if that port's reqN_valid = 1. At most one ready is high per cycle.
  - On handshake: latch op1/op2/ctrl and the grant index, then go to EXEC.
- Grant rule (round-robin):
  - If only one port is valid, that port wins.
  - If both are valid, the port named by the priority pointer wins.
  - After each grant, the pointer moves to the other port.
- EXEC:
  - alu_op1/op2/ctrl are driven from the latched registers.
  - At the end of the cycle, capture alu_result into rsp_result and alu_eq into rsp_eq, then go to RESP.
- RESP:
  - rspN_valid = 1 for the latched grant index only. The other rsp valid stays 0.
  - Leave for IDLE on rspN_ready = 1.
  - rsp_result and rsp_eq hold stable until then.
- Outside EXEC, alu_op1/op2/ctrl hold the last latched values; the ALU output is ignored.
- Requesters may drop reqN_valid before acceptance without side effects. Once accepted, the operation cannot be cancelled.
- No accept in RESP or EXEC: all reqN_ready = 0.

## Timing
- Reset values (applied while rst = 1 at a clock edge):
  - State IDLE; priority pointer = port 0; grant index = 0.
  - All latched operands, ctrl, rsp_result and rsp_eq = 0.
  - All rspN_valid = 0 and reqN_ready = 0.
- Latency: handshake at cycle T → ALU evaluated in T+1 → rspN_valid high from T+2.
- Minimum issue interval is 3 cycles (accept, EXEC, RESP with ready = 1 immediately). The next accept happens at the earliest in the cycle after the response handshake.
- Response backpressure: RESP holds indefinitely while rspN_ready = 0. Meanwhile any pending requests keep waiting.
- A simultaneous request on both ports in IDLE is decided by the pointer only. The losing port's valid stays asserted and it wins the next IDLE arbitration.
- Reset mid-operation (EXEC or RESP) discards the operation; no response is issued.
- rspN_ready while rspN_valid = 0 is ignored.

## Configuration
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined:
  - Port 0 always wins when both are valid, so port 1 can starve.
  - The priority pointer is not implemented.
- Undefined: round-robin as described under Operation.

## Structure
- A shared package alu_arb_pkg holds:
  - the state enum typedef (IDLE, EXEC, RESP)
  - the grant index typedef
  - the ALU control encoding constants: ADD 3'b000, SUB 3'b001, AND 3'b010, OR 3'b011, SLT 3'b101
- One natural sub-module, alu_arb_rr: a two-port round-robin grant generator holding the pointer register. It is bypassed when ALU_ARB_FIXED_PRIO_EN is defined.
- The ALU itself is instantiated outside this block.

## Test plan
- Single op: req0 with op1 = 5, op2 = 3, ctrl = 000 accepted at T → rsp0_valid at T+2 with rsp_result = 8, rsp_eq = 0. rsp1_valid stays 0.
- Equal compare: req1 with op1 = op2 = 0x1234, ctrl = 001 → rsp1_valid with rsp_result = 0, rsp_eq = 1.
- Contention: both ports valid continuously with ready tied high, default build → grants alternate 0, 1, 0, 1, with each accept 3 cycles apart. With ALU_ARB_FIXED_PRIO_EN defined → port 0 only.
- Backpressure: hold rsp0_ready = 0 for 5 cycles in RESP → rsp_result stable, both reqN_ready = 0. Release → IDLE next cycle, then a pending req1 is accepted.
- Reset mid-op: assert rst in EXEC → next cycle state IDLE, all valid/ready outputs 0, no response ever issued for that operation.
- SLT: op1 = 2, op2 = 7, ctrl = 101 → rsp_result = 1, rsp_eq = 0.
